// File: rtl/ps2_kbd_ascii_pkg.sv
// rtl/ps2_kbd_ascii_pkg.sv - scancode set 2 and ASCII constants, frame FSM state type
package ps2_kbd_ascii_pkg;

    localparam int KBD_W = 8;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_SHIFT_L  = 8'h12;
    localparam logic [7:0] SC_SHIFT_R  = 8'h59;
    localparam logic [7:0] SC_CTRL     = 8'h14;
    localparam logic [7:0] SC_CAPS     = 8'h58;
    localparam logic [7:0] SC_KP_ENTER = 8'h5A;
    localparam logic [7:0] SC_KP_SLASH = 8'h4A;

    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_ESC   = 8'h1B;
    localparam logic [7:0] ASCII_TAB   = 8'h09;
    localparam logic [7:0] ASCII_SLASH = 8'h2F;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_DATA,
        FR_PARITY,
        FR_STOP
    } frame_state_t;

    function automatic logic is_lower(input logic [7:0] c);
        return (c >= 8'h61) && (c <= 8'h7A);
    endfunction

endpackage

// File: rtl/ps2_kbd_ascii_fifo.sv
// rtl/ps2_kbd_ascii_fifo.sv - circular character queue with registered head output
module ps2_kbd_ascii_fifo
    import ps2_kbd_ascii_pkg::*;
#(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KBD_W-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic [KBD_W-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready,
    output logic             overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [KBD_W-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, rd_ptr_n;
    logic [CW-1:0]         count, count_n, kept;
    logic                  push_ok, pop_ok;

    // A pop frees a slot in the same cycle, so a full queue still accepts a push alongside it.
    always_comb begin
        pop_ok   = out_tready && (count != '0);
        push_ok  = in_tvalid && ((count != FULL) || pop_ok);
        rd_ptr_n = rd_ptr + DEPTH_LOG2'(pop_ok);
        kept     = count - CW'(pop_ok);
        count_n  = kept + CW'(push_ok);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= in_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_tdata <= '0;
            overflow  <= 1'b0;
        end else begin
            overflow <= in_tvalid && !push_ok;
            if (push_ok) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            rd_ptr <= rd_ptr_n;
            count  <= count_n;
            // The incoming char becomes head when nothing older remains after this cycle's pop.
            if (push_ok && (kept == '0)) begin
                out_tdata <= in_tdata;
            end else if (count_n != '0) begin
                out_tdata <= mem[rd_ptr_n];
            end
        end
    end

    assign out_tvalid = (count != '0);

endmodule

// File: rtl/ps2_scancode_rom.sv
// rtl/ps2_scancode_rom.sv - scancode set 2 make code to {shifted, plain} ASCII; 0 means no char
module ps2_scancode_rom
    import ps2_kbd_ascii_pkg::*;
(
    input  logic [7:0]  code,
    output logic [15:0] chars
);

    always_comb begin
        chars = 16'h0000;
        case (code)
            8'h1C: chars = "Aa";  8'h32: chars = "Bb";  8'h21: chars = "Cc";  8'h23: chars = "Dd";
            8'h24: chars = "Ee";  8'h2B: chars = "Ff";  8'h34: chars = "Gg";  8'h33: chars = "Hh";
            8'h43: chars = "Ii";  8'h3B: chars = "Jj";  8'h42: chars = "Kk";  8'h4B: chars = "Ll";
            8'h3A: chars = "Mm";  8'h31: chars = "Nn";  8'h44: chars = "Oo";  8'h4D: chars = "Pp";
            8'h15: chars = "Qq";  8'h2D: chars = "Rr";  8'h1B: chars = "Ss";  8'h2C: chars = "Tt";
            8'h3C: chars = "Uu";  8'h2A: chars = "Vv";  8'h1D: chars = "Ww";  8'h22: chars = "Xx";
            8'h35: chars = "Yy";  8'h1A: chars = "Zz";
            8'h16: chars = "!1";  8'h1E: chars = "@2";  8'h26: chars = "#3";  8'h25: chars = "$4";
            8'h2E: chars = "%5";  8'h36: chars = "^6";  8'h3D: chars = "&7";  8'h3E: chars = "*8";
            8'h46: chars = "(9";  8'h45: chars = ")0";
            8'h29: chars = "  ";  8'h4E: chars = "_-";  8'h55: chars = "+=";  8'h41: chars = "<,";
            8'h49: chars = ">.";  8'h4A: chars = "?/";  8'h4C: chars = ":;";  8'h52: chars = "\"'";
            8'h54: chars = "{[";  8'h5B: chars = "}]";  8'h5D: chars = "|\\"; 8'h0E: chars = {8'h7E, 8'h60};
            8'h5A: chars = {ASCII_CR, ASCII_CR};
            8'h66: chars = {ASCII_BS, ASCII_BS};
            8'h76: chars = {ASCII_ESC, ASCII_ESC};
            8'h0D: chars = {ASCII_TAB, ASCII_TAB};
            default: chars = 16'h0000;
        endcase
    end

endmodule

// File: rtl/ps2_kbd_ascii.sv
// rtl/ps2_kbd_ascii.sv - PS/2 keyboard deframer, scancode set 2 decoder and ASCII queue
module ps2_kbd_ascii
    import ps2_kbd_ascii_pkg::*;
#(
    parameter int CLK_FREQ        = 50000000,
    parameter int FILTER_LEN      = 8,
    parameter int TIMEOUT_US      = 2000,
    parameter int FIFO_DEPTH_LOG2 = 3
) (
    input  logic             clk50M,
    input  logic             rst,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic [KBD_W-1:0] kbd_data,
    output logic             kbd_int,
    input  logic             kbd_int_ack,
    output logic             frame_err,
    output logic             overflow
);

    localparam int TIMEOUT_CYC = CLK_FREQ / 1000000 * TIMEOUT_US;
    localparam int TW          = $clog2(TIMEOUT_CYC + 1);
    localparam int FW          = $clog2(FILTER_LEN + 1);

    logic [1:0]    clk_sync, data_sync;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic          strobe, strobe_bit;

    // Strobe and its data bit are registered together from the same synchronised sample.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            clk_filt   <= 1'b1;
            filt_cnt   <= '0;
            strobe     <= 1'b0;
            strobe_bit <= 1'b1;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            strobe     <= 1'b0;
            strobe_bit <= data_sync[1];
            if (clk_sync[1] == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                clk_filt <= clk_sync[1];
                filt_cnt <= '0;
                strobe   <= ~clk_sync[1];
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    frame_state_t  state, state_n;
    logic [2:0]    bit_cnt, bit_cnt_n;
    logic [7:0]    shreg, shreg_n;
    logic          par, par_n;
    logic [TW-1:0] idle_cyc;
    logic          timeout, byte_ok, byte_bad;

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par;
        byte_ok   = 1'b0;
        byte_bad  = 1'b0;
        timeout   = (state != FR_IDLE) && !strobe && (idle_cyc == TW'(TIMEOUT_CYC - 1));
        if (timeout) begin
            state_n  = FR_IDLE;
            byte_bad = 1'b1;
        end else if (strobe) begin
            case (state)
                FR_IDLE: begin
                    if (!strobe_bit) begin
                        state_n   = FR_DATA;
                        bit_cnt_n = '0;
                    end
                end
                FR_DATA: begin
                    shreg_n   = {strobe_bit, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        state_n = FR_PARITY;
                    end
                end
                FR_PARITY: begin
                    par_n   = strobe_bit;
                    state_n = FR_STOP;
                end
                FR_STOP: begin
                    state_n = FR_IDLE;
                    if (strobe_bit && (^{shreg, par})) begin
                        byte_ok = 1'b1;
                    end else begin
                        byte_bad = 1'b1;
                    end
                end
                default: state_n = FR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk50M) begin
        if (rst) begin
            state     <= FR_IDLE;
            bit_cnt   <= '0;
            shreg     <= '0;
            par       <= 1'b0;
            idle_cyc  <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            shreg     <= shreg_n;
            par       <= par_n;
            frame_err <= byte_bad;
            if ((state == FR_IDLE) || strobe) begin
                idle_cyc <= '0;
            end else begin
                idle_cyc <= idle_cyc + TW'(1);
            end
        end
    end

    logic [15:0]      rom_chars;
    logic [7:0]       plain, shifted, upper;
    logic             letter, shift;
    logic             brk, ext, shift_l, shift_r, ctrl, caps;
    logic             chr_tvalid;
    logic [KBD_W-1:0] chr_tdata;

    ps2_scancode_rom u_rom (
        .code  (shreg),
        .chars (rom_chars)
    );

    always_comb begin
        plain   = rom_chars[7:0];
        shifted = rom_chars[15:8];
        letter  = is_lower(plain);
        shift   = shift_l | shift_r;
        upper   = plain & 8'hDF;
    end

    // shreg still holds the byte while byte_ok is high: STOP does not shift.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            brk        <= 1'b0;
            ext        <= 1'b0;
            shift_l    <= 1'b0;
            shift_r    <= 1'b0;
            ctrl       <= 1'b0;
            caps       <= 1'b0;
            chr_tvalid <= 1'b0;
            chr_tdata  <= '0;
        end else begin
            chr_tvalid <= 1'b0;
            if (byte_ok) begin
                if (shreg == SC_BREAK) begin
                    brk <= 1'b1;
                end else if (shreg == SC_EXT) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                    if (shreg == SC_CTRL) begin
                        ctrl <= !brk;
                    end else if (ext) begin
                        if (!brk && ((shreg == SC_KP_ENTER) || (shreg == SC_KP_SLASH))) begin
                            chr_tvalid <= 1'b1;
                            chr_tdata  <= (shreg == SC_KP_ENTER) ? ASCII_CR : ASCII_SLASH;
                        end
                    end else if (shreg == SC_SHIFT_L) begin
                        shift_l <= !brk;
                    end else if (shreg == SC_SHIFT_R) begin
                        shift_r <= !brk;
                    end else if (shreg == SC_CAPS) begin
                        if (!brk) begin
                            caps <= !caps;
                        end
                    end else if (!brk && (plain != 8'h00)) begin
                        chr_tvalid <= 1'b1;
                        if (letter && ctrl) begin
                            chr_tdata <= upper & 8'h1F;
                        end else if (letter) begin
                            chr_tdata <= (shift ^ caps) ? upper : plain;
                        end else begin
                            chr_tdata <= shift ? shifted : plain;
                        end
                    end
                end
            end
        end
    end

    ps2_kbd_ascii_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk50M),
        .rst        (rst),
        .in_tdata   (chr_tdata),
        .in_tvalid  (chr_tvalid),
        .out_tdata  (kbd_data),
        .out_tvalid (kbd_int),
        .out_tready (kbd_int_ack),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_ps2_kbd_ascii.sv
// tb/tb_ps2_kbd_ascii.sv - self-checking bench for ps2_kbd_ascii
module tb_ps2_kbd_ascii;

    localparam int HALF   = 12;
    localparam int TO_CYC = 2000;

    logic       clk50M = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       kbd_int_ack = 1'b0;
    logic [7:0] kbd_data;
    logic       kbd_int, frame_err, overflow;

    int errors = 0;
    int checks = 0;
    int ovf_cnt = 0;
    int fe_cnt = 0;
    int exp_ovf = 0;
    int exp_fe = 0;

    logic [7:0] exp_q [$];
    logic [7:0] key_plain [logic [7:0]];
    logic [7:0] key_shift [logic [7:0]];
    logic [7:0] pool [16];
    logic [10:0] f;
    bit m_brk, m_ext, m_shl, m_shr, m_ctrl, m_caps;

    ps2_kbd_ascii #(
        .CLK_FREQ        (1000000),
        .FILTER_LEN      (8),
        .TIMEOUT_US      (2000),
        .FIFO_DEPTH_LOG2 (3)
    ) dut (
        .clk50M      (clk50M),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .kbd_data    (kbd_data),
        .kbd_int     (kbd_int),
        .kbd_int_ack (kbd_int_ack),
        .frame_err   (frame_err),
        .overflow    (overflow)
    );

    always #5 clk50M = ~clk50M;

    always @(negedge clk50M) begin
        if (overflow === 1'b1) ovf_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk50M);
        #1;
    endtask

    task automatic add_key(input logic [7:0] code, input logic [15:0] ps);
        key_plain[code] = ps[15:8];
        key_shift[code] = ps[7:0];
    endtask

    function automatic void model_emit(input logic [7:0] c);
        if (exp_q.size() >= 8) exp_ovf++;
        else exp_q.push_back(c);
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_brk = 0; m_ext = 0; m_shl = 0; m_shr = 0; m_ctrl = 0; m_caps = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [7:0] p;
        if (b == 8'hF0) begin m_brk = 1; return; end
        if (b == 8'hE0) begin m_ext = 1; return; end
        if (b == 8'h14) m_ctrl = !m_brk;
        else if (m_ext) begin
            if (!m_brk && b == 8'h5A) model_emit(8'h0D);
            if (!m_brk && b == 8'h4A) model_emit(8'h2F);
        end
        else if (b == 8'h12) m_shl = !m_brk;
        else if (b == 8'h59) m_shr = !m_brk;
        else if (b == 8'h58) begin if (!m_brk) m_caps = !m_caps; end
        else if (!m_brk && key_plain.exists(b)) begin
            p = key_plain[b];
            if (p >= 8'h61 && p <= 8'h7A) begin
                if (m_ctrl) model_emit(p - 8'h60);
                else if ((m_shl || m_shr) != m_caps) model_emit(p - 8'h20);
                else model_emit(p);
            end else begin
                model_emit((m_shl || m_shr) ? key_shift[b] : p);
            end
        end
        m_brk = 0;
        m_ext = 0;
    endfunction

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        return {1'b1, p, b, 1'b0};
    endfunction

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        step(HALF);
        ps2_clk = 1'b0;
        step(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [10:0] fr, input int nbits);
        for (int i = 0; i < nbits; i++) ps2_bit(fr[i]);
        ps2_data = 1'b1;
        step(HALF);
    endtask

    task automatic send_key(input logic [7:0] b);
        send_frame(mk_frame(b, 1'b0), 11);
        model_byte(b);
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() != 0) begin
            check({tag, "_int"}, 32'(kbd_int), 32'(1));
            check({tag, "_data"}, 32'(kbd_data), 32'(exp_q.pop_front()));
            kbd_int_ack = 1'b1;
            step(1);
            kbd_int_ack = 1'b0;
        end
        step(1);
        check({tag, "_empty"}, 32'(kbd_int), 32'(0));
    endtask

    initial begin
        add_key(8'h1C, "aA"); add_key(8'h32, "bB"); add_key(8'h21, "cC"); add_key(8'h23, "dD");
        add_key(8'h24, "eE"); add_key(8'h1A, "zZ"); add_key(8'h16, "1!"); add_key(8'h45, "0)");
        add_key(8'h29, "  "); add_key(8'h4E, "-_"); add_key(8'h55, "=+"); add_key(8'h4A, "/?");
        add_key(8'h66, {8'h08, 8'h08}); add_key(8'h76, {8'h1B, 8'h1B});
        add_key(8'h0D, {8'h09, 8'h09}); add_key(8'h5A, {8'h0D, 8'h0D});
        pool = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h1A, 8'h16, 8'h45,
                 8'h29, 8'h4E, 8'h55, 8'h66, 8'h76, 8'h0D, 8'h5A, 8'h4A};
        model_reset();

        step(5);
        check("reset_kbd_int", 32'(kbd_int), 32'(0));
        check("reset_kbd_data", 32'(kbd_data), 32'(0));
        check("reset_frame_err", 32'(frame_err), 32'(0));
        check("reset_overflow", 32'(overflow), 32'(0));
        rst = 1'b0;
        step(5);

        send_key(8'h1C);
        check("make_a_int", 32'(kbd_int), 32'(1));
        check("make_a_data", 32'(kbd_data), 32'(8'h61));
        send_key(8'hF0); send_key(8'h1C);
        drain("make_a");

        send_key(8'h12); send_key(8'h1C); send_key(8'hF0); send_key(8'h1C);
        send_key(8'hF0); send_key(8'h12); send_key(8'h1C); send_key(8'hF0); send_key(8'h1C);
        drain("shift");

        send_key(8'h58); send_key(8'hF0); send_key(8'h58); send_key(8'h1C); send_key(8'hF0); send_key(8'h1C);
        send_key(8'h12); send_key(8'h1C); send_key(8'hF0); send_key(8'h1C); send_key(8'hF0); send_key(8'h12);
        send_key(8'h58); send_key(8'hF0); send_key(8'h58);
        drain("caps");

        send_key(8'h14); send_key(8'h21); send_key(8'hF0); send_key(8'h21); send_key(8'hF0); send_key(8'h14);
        drain("ctrl_c");

        send_key(8'hE0); send_key(8'h75); send_key(8'hE0); send_key(8'hF0); send_key(8'h75);
        send_key(8'hE0); send_key(8'h5A); send_key(8'hE0); send_key(8'hF0); send_key(8'h5A);
        drain("ext");

        send_frame(mk_frame(8'h1C, 1'b1), 11);
        exp_fe++;
        step(5);
        check("bad_parity_err", 32'(fe_cnt), 32'(exp_fe));
        drain("bad_parity");

        send_frame(mk_frame(8'h1C, 1'b0), 4);
        step(TO_CYC + 100);
        exp_fe++;
        check("timeout_err", 32'(fe_cnt), 32'(exp_fe));
        send_key(8'h32); send_key(8'hF0); send_key(8'h32);
        drain("after_timeout");

        repeat (10) send_key(8'h16);
        send_key(8'hF0); send_key(8'h16);
        check("overflow_cnt", 32'(ovf_cnt), 32'(exp_ovf));
        check("overflow_expect2", 32'(exp_ovf), 32'(2));
        drain("overflow");

        for (int k = 6; k <= 16; k++) begin
            send_key(8'h1C);
            f = mk_frame(8'h32, 1'b0);
            for (int i = 0; i < 10; i++) ps2_bit(f[i]);
            ps2_data = 1'b1;
            step(HALF);
            ps2_clk = 1'b0;
            step(k);
            kbd_int_ack = 1'b1;
            step(1);
            kbd_int_ack = 1'b0;
            step(20 - k - 1);
            ps2_clk = 1'b1;
            step(HALF);
            model_byte(8'h32);
            void'(exp_q.pop_front());
            check("coinc_int", 32'(kbd_int), 32'(1));
            check("coinc_data", 32'(kbd_data), 32'(exp_q[0]));
            drain("coinc");
        end

        send_key(8'h58); send_key(8'hF0); send_key(8'h58);
        send_key(8'h1C); send_key(8'h32); send_key(8'h16);
        f = mk_frame(8'h29, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(f[i]);
        rst = 1'b1;
        step(1);
        check("rst_mid_int", 32'(kbd_int), 32'(0));
        rst = 1'b0;
        ps2_data = 1'b1;
        model_reset();
        step(HALF);
        send_key(8'h1C); send_key(8'hF0); send_key(8'h1C);
        drain("after_rst");

        ps2_data = 1'b0;
        ps2_clk = 1'b0;
        step(4);
        ps2_clk = 1'b1;
        ps2_data = 1'b1;
        step(TO_CYC + 100);
        check("glitch_no_err", 32'(fe_cnt), 32'(exp_fe));
        send_key(8'h29); send_key(8'hF0); send_key(8'h29);
        drain("after_glitch");

        for (int it = 0; it < 20; it++) begin
            logic [7:0] code;
            bit use_shift, use_ctrl;
            code = pool[$urandom_range(0, 15)];
            use_shift = ($urandom_range(0, 2) == 0);
            use_ctrl = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 4) == 0) begin
                send_key(8'h58); send_key(8'hF0); send_key(8'h58);
            end
            if (use_shift) send_key(8'h59);
            if (use_ctrl) send_key(8'h14);
            send_key(code); send_key(8'hF0); send_key(code);
            if (use_ctrl) begin send_key(8'hF0); send_key(8'h14); end
            if (use_shift) begin send_key(8'hF0); send_key(8'h59); end
            if (it % 4 == 3) drain("random");
        end
        drain("random_end");
        check("final_overflow", 32'(ovf_cnt), 32'(exp_ovf));
        check("final_frame_err", 32'(fe_cnt), 32'(exp_fe));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
